// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: write frames commit on nCS rise; optional readback
// of the addressed register on CIPO, enabled by macro SPI_REG_BANK_READBACK_EN.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FL = 1 + ADDR_W + DATA_W;
  localparam int HL = 1 + ADDR_W;
  localparam int CW = $clog2(FL + 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_ncs_sync;
  logic [1:0]        r_sclk_sync;
  logic [1:0]        r_copi_sync;
  logic              r_ncs_d;
  logic              r_sclk_d;
  logic [CW-1:0]     r_bit_cnt;
  logic [FL-1:0]     r_shift_in;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_ncs_fall;
  logic              w_ncs_rise;
  logic              w_sclk_rise;
  logic              w_sample;
  logic [FL-1:0]     w_shift_nxt;
  logic              w_rx_rw;
  logic [ADDR_W-1:0] w_rx_addr;
  logic [DATA_W-1:0] w_rx_data;
  logic              w_addr_ok;
  logic              w_commit;
  logic              w_abort;

  // Synchronisers plus one delay stage for edge detection; nCS idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs_sync  <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_copi_sync <= 2'b00;
      r_ncs_d     <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ncs_sync  <= {r_ncs_sync[0], nCS};
      r_sclk_sync <= {r_sclk_sync[0], SCLK};
      r_copi_sync <= {r_copi_sync[0], COPI};
      r_ncs_d     <= r_ncs_sync[1];
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  assign w_ncs_fall  = r_ncs_d & ~r_ncs_sync[1];
  assign w_ncs_rise  = ~r_ncs_d & r_ncs_sync[1];
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
  assign cipo_oe     = ~r_ncs_sync[1];

  assign w_shift_nxt = {r_shift_in[FL-2:0], r_copi_sync[1]};
  assign w_rx_rw     = r_shift_in[FL-1];
  assign w_rx_addr   = r_shift_in[FL-2 -: ADDR_W];
  assign w_rx_data   = r_shift_in[DATA_W-1:0];
  assign w_addr_ok   = ({1'b0, w_rx_addr} < (ADDR_W+1)'(NUM_REGS));
  assign w_commit    = w_ncs_rise && (r_bit_cnt == CW'(FL)) && w_rx_rw && w_addr_ok;
  assign w_abort     = w_ncs_rise && (r_bit_cnt != CW'(0)) && (r_bit_cnt != CW'(FL));

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and bit-sample enable; nCS edges override everything.
  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    if (w_ncs_rise) begin
      w_state_nxt = IDLE;
    end else if (w_ncs_fall) begin
      w_state_nxt = HEADER;
    end else begin
      case (r_state)
        HEADER: begin
          w_sample = w_sclk_rise;
          if (w_sclk_rise && (r_bit_cnt == CW'(HL-1))) w_state_nxt = DATA;
          else                                         w_state_nxt = HEADER;
        end
        DATA: begin
          w_sample = w_sclk_rise;
          if (w_sclk_rise && (r_bit_cnt == CW'(FL-1))) w_state_nxt = WAIT;
          else                                         w_state_nxt = DATA;
        end
        WAIT:    w_state_nxt = WAIT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Shift-in, bit count and the registered commit/abort outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_shift_in <= '0;
      wr_strobe  <= 1'b0;
      frame_err  <= 1'b0;
      wr_addr    <= '0;
    end else begin
      wr_strobe <= w_commit;
      frame_err <= w_abort;
      if (w_commit) wr_addr <= w_rx_addr;
      if (w_ncs_fall) begin
        r_bit_cnt  <= '0;
        r_shift_in <= '0;
      end else if (w_ncs_rise) begin
        r_bit_cnt  <= '0;
      end else if (w_sample) begin
        r_bit_cnt  <= r_bit_cnt + CW'(1);
        r_shift_in <= w_shift_nxt;
      end
    end
  end

  // Register file; only a validated write frame changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && (w_rx_addr == ADDR_W'(i))) r_regs[i] <= w_rx_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
  end

`ifdef SPI_REG_BANK_READBACK_EN
  logic              w_sclk_fall;
  logic              w_hdr_done;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_shift_out;
  logic              r_cipo;

  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
  assign w_hdr_done  = w_sample && (r_bit_cnt == CW'(HL-1));

  // Readback mux on the header just completing; unimplemented addresses read 0.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rd_data = (w_shift_nxt[ADDR_W-1:0] == ADDR_W'(i)) ? r_regs[i] : w_rd_data;
    end
  end

  // Shift-out register: loaded at header end, one bit out per SCLK fall in DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_out <= '0;
      r_cipo      <= 1'b0;
    end else begin
      if (w_hdr_done) begin
        r_shift_out <= w_shift_nxt[HL-1] ? '0 : w_rd_data;
      end else if ((r_state == DATA) && w_sclk_fall) begin
        r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
      end
      if (w_state_nxt != DATA) begin
        r_cipo <= 1'b0;
      end else if ((r_state == DATA) && w_sclk_fall) begin
        r_cipo <= r_shift_out[DATA_W-1];
      end
    end
  end

  assign CIPO = r_cipo;
`else
  assign CIPO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: frames push expected commit/abort events,
// a negedge monitor pops and compares them whenever wr_strobe or frame_err fires.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nCS;
  logic        SCLK;
  logic        COPI;
  logic        CIPO;
  logic        cipo_oe;
  logic [39:0] reg_q;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_err;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
    .CIPO(CIPO), .cipo_oe(cipo_oe), .reg_q(reg_q), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [39:0] model_regs;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  logic [7:0]  rd_bits;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    e.err = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
    model_regs[a*8 +: 8] = d;
  endtask

  task automatic expect_err();
    ev_t e;
    e.err = 1'b1; e.addr = 7'd0; e.data = 8'd0;
    exp_q.push_back(e);
  endtask

  // Send npulse SCLK pulses of frame f (bits past 16 are zeros), capturing CIPO in the data phase.
  task automatic frame(input logic [15:0] f, input int npulse, input logic raise);
    nCS = 1'b0;
    tick(4);
    check("cipo_oe_in_frame", cipo_oe, 1'b1);
    for (int i = 0; i < npulse; i++) begin
      COPI = (i < 16) ? f[15-i] : 1'b0;
      tick(4);
      if (i >= 8 && i < 16) rd_bits = {rd_bits[6:0], CIPO};
      SCLK = 1'b1;
      tick(4);
      SCLK = 1'b0;
    end
    tick(4);
    if (raise) begin
      nCS = 1'b1;
      rise_cyc = cyc;
      tick(10);
      check("cipo_oe_idle", cipo_oe, 1'b0);
      check("cipo_idle", CIPO, 1'b0);
      check("regs_after_frame", reg_q, model_regs);
    end
  endtask

  // Monitor: every strobe or abort must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (wr_strobe || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_event strobe=%0b frame_err=%0b addr=0x%0h", wr_strobe, frame_err, wr_addr);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", {wr_strobe, frame_err}, e.err ? 2'b01 : 2'b10);
        if (!e.err) begin
          check("wr_addr", wr_addr, e.addr);
          check("reg_at_strobe", (reg_q >> (e.addr * 8)) & 40'hFF, e.data);
          check("strobe_latency", cyc - rise_cyc, 3);
        end
      end
    end
  end

  initial begin
    int w;
    logic [7:0] exp_rd;
    rst_n = 1'b0; nCS = 1'b1; SCLK = 1'b0; COPI = 1'b0;
    model_regs = 40'h0;
    rd_bits = 8'h00;
    tick(3);
    check("rst_reg_q", reg_q, 40'h0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_cipo", CIPO, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h00);
    rst_n = 1'b1;
    tick(4);

    expect_wr(7'h00, 8'hA5);
    frame(16'h80A5, 16, 1'b1);

    expect_wr(7'h04, 8'h3C);
    frame(16'h843C, 16, 1'b1);
    frame(16'h8501, 16, 1'b1);

    expect_wr(7'h02, 8'h5A);
    frame(16'h825A, 16, 1'b1);
    frame(16'h0200, 16, 1'b1);
`ifdef SPI_REG_BANK_READBACK_EN
    exp_rd = 8'h5A;
`else
    exp_rd = 8'h00;
`endif
    check("readback_bits", rd_bits, exp_rd);

    expect_err();
    frame(16'h81FF, 10, 1'b1);

    frame(16'h83C3, 12, 1'b0);
    rst_n = 1'b0;
    tick(2);
    nCS = 1'b1;
    SCLK = 1'b0;
    tick(2);
    model_regs = 40'h0;
    check("regs_cleared_by_reset", reg_q, model_regs);
    rst_n = 1'b1;
    tick(6);
    expect_wr(7'h03, 8'h11);
    frame(16'h8311, 16, 1'b1);

    expect_wr(7'h00, 8'hF0);
    frame(16'h80F0, 20, 1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick(1);
      w++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
